// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: reset-source inputs and reset/status outputs
// of the reset sequencer; slave is the sequencer, master the system.
interface rst_seq_ctrl_if #(
  parameter int NumResets = 3
);
  logic                 pll_locked_i;
  logic                 rst_btn_i;
  logic                 sw_rst_req_i;
  logic                 wdog_kick_i;
  logic                 rst_cause_clr_i;
  logic [NumResets-1:0] rst_no;
  logic [3:0]           rst_cause_o;
  logic                 busy_o;

  modport master (
    output pll_locked_i,
    output rst_btn_i,
    output sw_rst_req_i,
    output wdog_kick_i,
    output rst_cause_clr_i,
    input  rst_no,
    input  rst_cause_o,
    input  busy_o
  );

  modport slave (
    input  pll_locked_i,
    input  rst_btn_i,
    input  sw_rst_req_i,
    input  wdog_kick_i,
    input  rst_cause_clr_i,
    output rst_no,
    output rst_cause_o,
    output busy_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: PLL-gated staggered reset sequencer with sticky cause.
// Watchdog trigger is built only when RST_SEQ_CTRL_WDOG_EN is defined.
module rst_seq_ctrl #(
  parameter int NumResets     = 3,
  parameter int HoldCount     = 200,
  parameter int StaggerCount  = 16,
  parameter int DebounceCount = 500,
  parameter int WdogCount     = 2**20
) (
  input logic           clk_i,
  input logic           rst_i,
  rst_seq_ctrl_if.slave bus
);

  localparam int MaxCnt =
    (HoldCount > StaggerCount) ? HoldCount : StaggerCount;
  localparam int CntW = $clog2(MaxCnt + 1);
  localparam int DbW  = $clog2(DebounceCount + 1);

  localparam logic [CntW-1:0] HoldLast =
    CntW'(HoldCount - 1);
  localparam logic [CntW-1:0] StagLast =
    CntW'(StaggerCount - 1);
  localparam logic [DbW-1:0] DbLast =
    DbW'(DebounceCount - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    ASSERT,
    RELEASE,
    RUN
  } state_e;

  state_e state_q, state_d;

  logic [1:0]           lock_sync_q;
  logic [1:0]           btn_sync_q;
  logic                 btn_db_q, btn_db_d;
  logic [DbW-1:0]       db_cnt_q, db_cnt_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      cnt_inc;
  logic [NumResets-1:0] rst_no_q, rst_no_d;
  logic [NumResets-1:0] rst_no_inc;
  logic [3:0]           cause_q, cause_d;
  logic [3:0]           cause_set;

  logic lock_ok;
  logic trig_btn;
  logic trig_sw;
  logic trig_wd;
  logic trig_any;

  // Synchronisers and debouncer see only rst_i, so a held
  // button keeps its debounced level across internal resets.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
      btn_db_q    <= 1'b0;
      db_cnt_q    <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], bus.pll_locked_i};
      btn_sync_q  <= {btn_sync_q[0], bus.rst_btn_i};
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_sync_q[1] != btn_db_q) begin
      if (db_cnt_q == DbLast) begin
        btn_db_d = btn_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

`ifdef RST_SEQ_CTRL_WDOG_EN
  localparam int WdW = $clog2(WdogCount + 1);
  localparam logic [WdW-1:0] WdLast =
    WdW'(WdogCount - 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;

  // Holds at the terminal count; leaving RUN clears it.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == RUN && !bus.wdog_kick_i) begin
      if (wd_cnt_q == WdLast) begin
        wd_cnt_d = wd_cnt_q;
      end else begin
        wd_cnt_d = wd_cnt_q + WdW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign trig_wd = (state_q == RUN)
                && (wd_cnt_q == WdLast)
                && !bus.wdog_kick_i;
`else
  localparam int unused_wdog_count = WdogCount;
  logic unused_kick;
  assign unused_kick = bus.wdog_kick_i;
  assign trig_wd     = 1'b0;
`endif

  assign lock_ok  = lock_sync_q[1];
  assign trig_btn = btn_db_q;
  assign trig_sw  = bus.sw_rst_req_i;
  assign trig_any = trig_btn | trig_sw | trig_wd;

  assign cause_set = {trig_wd, trig_sw, trig_btn, ~lock_ok};

  always_comb begin
    cause_d = bus.rst_cause_clr_i ? 4'b0000 : cause_q;
    cause_d = cause_d | cause_set;
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);

  // Thermometer fill: each release sets the next domain bit.
  assign rst_no_inc = (rst_no_q << 1) | NumResets'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      rst_no_q <= '0;
      cause_q  <= 4'b0001;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rst_no_q <= rst_no_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rst_no_d = rst_no_q;
    if (!lock_ok) begin
      state_d  = WAIT_LOCK;
      cnt_d    = '0;
      rst_no_d = '0;
    end else if (trig_any && state_q != WAIT_LOCK) begin
      state_d  = ASSERT;
      cnt_d    = '0;
      rst_no_d = '0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
        ASSERT: begin
          if (cnt_q == HoldLast) begin
            cnt_d    = '0;
            rst_no_d = rst_no_inc;
            state_d  = (&rst_no_inc) ? RUN : RELEASE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RELEASE: begin
          if (cnt_q == StagLast) begin
            cnt_d    = '0;
            rst_no_d = rst_no_inc;
            state_d  = (&rst_no_inc) ? RUN : RELEASE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          rst_no_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.busy_o      = (state_q != RUN);
    bus.rst_no      = rst_no_q;
    bus.rst_cause_o = cause_q;
  end

endmodule
